// File: rtl/mesi_sector_controller.sv
// mesi_sector_controller: snoopy MESI controller for NUM_LINES sectors.
// A single CPU transaction FSM (IDLE/FILL/WAIT_INV) shares a per-line state
// array with an always-on snoop path and a one-deep write-back tracker.
// The state array stays in flops because every cycle needs simultaneous reads
// at the CPU index and the snoop index, plus up to three independent writes.
module mesi_sector_controller #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int NUM_PEERS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_write,
  input  logic [IDX_W-1:0] cpu_index,
  output logic             cpu_done,
  output logic             cpu_retry,
  output logic             fill_req,
  output logic [IDX_W-1:0] fill_index,
  input  logic             fill_done,
  input  logic             fill_abort,
  input  logic             bus_shared,
  output logic             inv_req,
  input  logic             inv_ack,
  input  logic             snoop_valid,
  input  logic             snoop_write,
  input  logic [IDX_W-1:0] snoop_index,
  output logic             snoop_hit,
  output logic             snoop_retry,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_index,
  input  logic             wb_done
);

  localparam int ACK_W = $clog2(NUM_PEERS + 1);

  typedef enum logic [1:0] {
    LINE_I = 2'd0,
    LINE_S = 2'd1,
    LINE_E = 2'd2,
    LINE_M = 2'd3
  } line_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_WAIT_INV = 2'd2
  } fsm_t;

  // Per-line coherence state
  line_t line_reg [NUM_LINES];

  // Transaction FSM registers
  fsm_t             state_reg, state_next;
  logic             req_write_reg, req_write_next;
  logic [IDX_W-1:0] req_index_reg, req_index_next;
  logic [ACK_W-1:0] ack_cnt_reg, ack_cnt_next;
  logic             fill_req_reg, fill_req_next;
  logic             inv_req_reg, inv_req_next;
  logic             cpu_done_reg, cpu_done_next;
  logic             cpu_retry_reg, cpu_retry_next;

  // Snoop response and write-back registers
  logic             snoop_hit_reg, snoop_hit_next;
  logic             snoop_retry_reg, snoop_retry_next;
  logic             wb_req_reg;
  logic [IDX_W-1:0] wb_index_reg;
  logic             wb_inval_reg;
  logic             wb_start;

  // Line-array write ports (snoop has priority, then write-back, then CPU)
  logic             cpu_wr_en;
  logic [IDX_W-1:0] cpu_wr_idx;
  line_t            cpu_wr_val;
  logic             snp_wr_en;
  line_t            snp_wr_val;
  logic             wb_wr_en;
  line_t            wb_wr_val;

  line_t            cpu_line;
  line_t            snp_line;
  logic [ACK_W-1:0] ack_inc;

  assign cpu_line = line_reg[cpu_index];
  assign snp_line = line_reg[snoop_index];
  assign ack_inc  = ack_cnt_reg + ACK_W'(1);

  // Accept only when idle and no snoop races the same sector this cycle
  assign cpu_ready = (state_reg == ST_IDLE) && !reset &&
                     !(snoop_valid && (snoop_index == cpu_index));

  assign cpu_done    = cpu_done_reg;
  assign cpu_retry   = cpu_retry_reg;
  assign fill_req    = fill_req_reg;
  assign fill_index  = req_index_reg;
  assign inv_req     = inv_req_reg;
  assign snoop_hit   = snoop_hit_reg;
  assign snoop_retry = snoop_retry_reg;
  assign wb_req      = wb_req_reg;
  assign wb_index    = wb_index_reg;

  // Transaction FSM: next state, registered-output next values, CPU line writes
  always_comb begin
    state_next     = state_reg;
    req_write_next = req_write_reg;
    req_index_next = req_index_reg;
    ack_cnt_next   = ack_cnt_reg;
    fill_req_next  = fill_req_reg;
    inv_req_next   = 1'b0;
    cpu_done_next  = 1'b0;
    cpu_retry_next = 1'b0;
    cpu_wr_en      = 1'b0;
    cpu_wr_idx     = req_index_reg;
    cpu_wr_val     = LINE_I;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_valid && cpu_ready) begin
          req_write_next = cpu_write;
          req_index_next = cpu_index;
          cpu_wr_idx     = cpu_index;
          case (cpu_line)
            LINE_I: begin
              fill_req_next = 1'b1;
              state_next    = ST_FILL;
            end
            LINE_S: begin
              if (cpu_write) begin
                inv_req_next = 1'b1;
                state_next   = ST_WAIT_INV;
              end else begin
                cpu_done_next = 1'b1;
              end
            end
            LINE_E: begin
              cpu_done_next = 1'b1;
              if (cpu_write) begin
                cpu_wr_en  = 1'b1;
                cpu_wr_val = LINE_M;
              end
            end
            default: cpu_done_next = 1'b1;
          endcase
        end
      end
      ST_FILL: begin
        if (fill_abort) begin
          // A peer owns the line Modified: give up and let the CPU reissue
          fill_req_next  = 1'b0;
          cpu_done_next  = 1'b1;
          cpu_retry_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (fill_done) begin
          fill_req_next = 1'b0;
          cpu_wr_en     = 1'b1;
          if (req_write_reg) begin
            cpu_wr_val   = LINE_S;
            inv_req_next = 1'b1;
            state_next   = ST_WAIT_INV;
          end else begin
            cpu_wr_val    = bus_shared ? LINE_S : LINE_E;
            cpu_done_next = 1'b1;
            state_next    = ST_IDLE;
          end
        end
      end
      ST_WAIT_INV: begin
        if (snoop_valid && snoop_write && (snoop_index == req_index_reg)) begin
          // Another writer won the sector; the snoop path invalidates it
          cpu_done_next  = 1'b1;
          cpu_retry_next = 1'b1;
          ack_cnt_next   = '0;
          state_next     = ST_IDLE;
        end else if (inv_ack) begin
          if (ack_inc == ACK_W'(NUM_PEERS)) begin
            cpu_wr_en     = 1'b1;
            cpu_wr_val    = LINE_M;
            cpu_done_next = 1'b1;
            ack_cnt_next  = '0;
            state_next    = ST_IDLE;
          end else begin
            ack_cnt_next = ack_inc;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM and CPU-side output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      req_write_reg <= 1'b0;
      req_index_reg <= '0;
      ack_cnt_reg   <= '0;
      fill_req_reg  <= 1'b0;
      inv_req_reg   <= 1'b0;
      cpu_done_reg  <= 1'b0;
      cpu_retry_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_write_reg <= req_write_next;
      req_index_reg <= req_index_next;
      ack_cnt_reg   <= ack_cnt_next;
      fill_req_reg  <= fill_req_next;
      inv_req_reg   <= inv_req_next;
      cpu_done_reg  <= cpu_done_next;
      cpu_retry_reg <= cpu_retry_next;
    end
  end

  // Snoop evaluation: response, line downgrade and write-back launch
  always_comb begin
    snoop_hit_next   = 1'b0;
    snoop_retry_next = 1'b0;
    snp_wr_en        = 1'b0;
    snp_wr_val       = LINE_I;
    wb_start         = 1'b0;
    if (snoop_valid) begin
      case (snp_line)
        LINE_S: begin
          snoop_hit_next = 1'b1;
          if (snoop_write) begin
            snp_wr_en  = 1'b1;
            snp_wr_val = LINE_I;
          end
        end
        LINE_E: begin
          snoop_hit_next = 1'b1;
          snp_wr_en      = 1'b1;
          snp_wr_val     = snoop_write ? LINE_I : LINE_S;
        end
        LINE_M: begin
          // Dirty data must reach memory first; the line stays M until wb_done
          snoop_hit_next   = 1'b1;
          snoop_retry_next = 1'b1;
          wb_start         = !wb_req_reg;
        end
        default: ;
      endcase
    end
  end

  // Write-back completion downgrades the written-back line
  always_comb begin
    wb_wr_en  = wb_req_reg && wb_done;
    wb_wr_val = wb_inval_reg ? LINE_I : LINE_S;
  end

  // Snoop response and single outstanding write-back registers
  always_ff @(posedge clk) begin
    if (reset) begin
      snoop_hit_reg   <= 1'b0;
      snoop_retry_reg <= 1'b0;
      wb_req_reg      <= 1'b0;
      wb_index_reg    <= '0;
      wb_inval_reg    <= 1'b0;
    end else begin
      snoop_hit_reg   <= snoop_hit_next;
      snoop_retry_reg <= snoop_retry_next;
      if (wb_start) begin
        wb_req_reg   <= 1'b1;
        wb_index_reg <= snoop_index;
        wb_inval_reg <= snoop_write;
      end else if (wb_wr_en) begin
        wb_req_reg <= 1'b0;
      end
    end
  end

  // Per-line state update; write ports never legitimately collide, the
  // priority only pins down behaviour if they ever do
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (reset) begin
          line_reg[gi] <= LINE_I;
        end else if (snp_wr_en && (snoop_index == IDX_W'(gi))) begin
          line_reg[gi] <= snp_wr_val;
        end else if (wb_wr_en && (wb_index_reg == IDX_W'(gi))) begin
          line_reg[gi] <= wb_wr_val;
        end else if (cpu_wr_en && (cpu_wr_idx == IDX_W'(gi))) begin
          line_reg[gi] <= cpu_wr_val;
        end
      end
    end
  endgenerate

endmodule

// File: doc/mesi_sector_controller.md
Name: mesi_sector_controller

Overview:
- Multi-line snoopy MESI coherence controller for one processor's cache. Generalises the single-sector state machine to NUM_LINES sectors held in an internal state array.
- Adds a CPU valid/ready request port, counted invalidation acks from NUM_PEERS peers, a write-back handshake and a registered snoop response.
- Sits between the CPU-side cache controller and the shared snoop bus.

Parameters:
NUM_LINES, 16, number of tracked sectors (power of 2, >=2)
IDX_W, $clog2(NUM_LINES), sector index width (derived, not overridden)
NUM_PEERS, 1, number of other caches that must acknowledge an invalidate (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_valid  in  1  CPU request valid
cpu_ready  out  1  controller can accept a request (combinational)
cpu_write  in  1  1=write, 0=read
cpu_index  in  IDX_W  sector addressed
cpu_done  out  1  one-cycle pulse: request completed
cpu_retry  out  1  qualifies cpu_done: request aborted, CPU must reissue
fill_req  out  1  memory sector fill request, held until fill_done/fill_abort
fill_index  out  IDX_W  sector being filled
fill_done  in  1  fill complete pulse
fill_abort  in  1  fill aborted by a peer holding the line Modified
bus_shared  in  1  sampled with fill_done: a peer holds a copy
inv_req  out  1  one-cycle invalidate broadcast pulse
inv_ack  in  1  one pulse per acknowledging peer
snoop_valid  in  1  bus snoop valid
snoop_write  in  1  1=snoop write, 0=snoop read
snoop_index  in  IDX_W  snooped sector
snoop_hit  out  1  registered, one cycle after snoop: line was valid (S/E/M)
snoop_retry  out  1  registered: requester must retry (AdrRetry)
wb_req  out  1  write-back request, held until wb_done
wb_index  out  IDX_W  sector being written back
wb_done  in  1  write-back complete pulse

Behaviour:
- Line encoding: I=0, S=1, E=2, M=3, 2 bits per line. Transaction FSM states: IDLE, FILL, WAIT_INV.
- Reset (sync): all lines I; FSM IDLE; inv-ack count 0; all outputs 0; write-back idle. cpu_ready is 0 during the reset cycle.
- cpu_ready = FSM==IDLE && !reset && !(snoop_valid && snoop_index==cpu_index). A request is accepted on cpu_valid && cpu_ready.
- Read on S/E/M: cpu_done next cycle; state unchanged.
- Write on M: cpu_done next cycle.
- Write on E: line -> M; cpu_done next cycle.
- Write on S: inv_req pulse next cycle; FSM -> WAIT_INV.
- Miss (line I): fill_req high next cycle; FSM -> FILL.
- FILL exits:
  - fill_abort: line stays I; cpu_done+cpu_retry next cycle; FSM -> IDLE. fill_abort wins over a simultaneous fill_done.
  - fill_done on a read: line -> S if bus_shared, else E; cpu_done next cycle.
  - fill_done on a write: line -> S; inv_req pulse next cycle; FSM -> WAIT_INV.
- WAIT_INV:
  - Counts inv_ack pulses, one per cycle max.
  - Count reaching NUM_PEERS: line -> M; cpu_done next cycle; count cleared.
  - inv_ack outside WAIT_INV is ignored.
- Snoop is evaluated every cycle, independent of FSM. Responses appear at edge+1.
  - Snoop read: S -> hit, no change. E -> hit, line -> S. M -> hit+retry, write-back of line starts, line -> S on wb_done. I -> no hit.
  - Snoop write: S/E -> hit, line -> I. M -> hit+retry, write-back starts, line -> I on wb_done. I -> no hit.
- Write-back: one outstanding. wb_req/wb_index are set the cycle after the snoop and held until wb_done. Line state stays M until wb_done.
  - A snoop hitting any M line while a write-back is pending returns retry=1, hit=1, with no state change.
  - A CPU write to a line under write-back completes as a write hit on M.
- Snoop to the FILL index: line is I, so no hit and no effect.
- Snoop write to the WAIT_INV index: line -> I; transaction aborts; cpu_done+cpu_retry next cycle; FSM IDLE; ack count cleared.
- Snoop read to the WAIT_INV index (S): hit, no change.
- Mid-operation reset: all of the above return to reset values at the next edge; fill_req, wb_req and the ack count drop.

Test Plan:
- Reset, then read idx 3 with bus_shared=0: fill_req=1, fill_index=3; after fill_done -> line 3 = E, cpu_done=1, cpu_retry=0. Repeat read of idx 3 -> cpu_done after 1 cycle, no fill_req.
- Line 5 in S, NUM_PEERS=3, write idx 5: inv_req pulse. Two acks -> no done. Third ack -> line 5 = M, cpu_done next cycle.
- Line 7 in M, snoop read idx 7: next cycle snoop_hit=1, snoop_retry=1, wb_req=1, wb_index=7. A second snoop to M line 2 before wb_done -> retry=1, line 2 stays M. On wb_done -> line 7 = S, wb_req=0.
- Write miss idx 9 with fill_abort and fill_done asserted in the same cycle: line 9 stays I, cpu_done=1, cpu_retry=1.
- In WAIT_INV on idx 4, snoop write idx 4: line 4 = I, cpu_done+cpu_retry. Later inv_ack pulses are ignored. Also: snoop_valid on idx==cpu_index forces cpu_ready=0 in that cycle.
- Assert reset during FILL with wb_req pending: next edge all lines I, fill_req=0, wb_req=0, cpu_done=0, FSM IDLE.
